// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the iterative approximate multiplier.
package approx_mult_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_PROD_W = 2 * DEF_WIDTH;

    // Keep-mask with the k low bits cleared; callers slice it to their operand width.
    function automatic logic [63:0] trunc_mask(input int unsigned k);
        return ~((64'd1 << k) - 64'd1);
    endfunction

endpackage

// File: rtl/approx_operand_prep.sv
// Operand conditioning: optional LSB truncation, then sign/magnitude split.
module approx_operand_prep
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int KW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in_x,
    input  logic             in_signed,
    input  logic             approx_en,
    input  logic [KW-1:0]    trunc_k,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_sign
);

    logic [63:0]      w_mask_full;
    logic [WIDTH-1:0] w_xt;

    always_comb begin
        w_mask_full = trunc_mask(32'(trunc_k));
        w_xt        = approx_en ? (in_x & w_mask_full[WIDTH-1:0]) : in_x;
        out_sign    = in_signed & w_xt[WIDTH-1];
        // Negating the most negative value wraps back to 2^(WIDTH-1), which is its magnitude.
        out_mag     = out_sign ? (~w_xt + WIDTH'(1)) : w_xt;
    end

endmodule

// File: rtl/approx_mult_iter.sv
// Iterative shift-add multiplier with signed mode, operand truncation and
// valid/ready handshakes; fixed WIDTH-cycle latency from accept to result.
module approx_mult_iter
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int KW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic               approx_en,
    input  logic [KW-1:0]      trunc_k,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;

    state_t           r_state;
    logic [KW-1:0]    r_cnt;
    logic [PW-1:0]    r_acc;
    logic [WIDTH-1:0] r_ma;
    logic [WIDTH-1:0] r_mb;
    logic             r_neg;
    logic [PW-1:0]    r_product;
    logic             r_out_valid;
    logic             r_busy;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [PW-1:0]    w_ma_sh;
    logic [PW-1:0]    w_acc_next;
    logic             w_last;

    approx_operand_prep #(.WIDTH(WIDTH), .KW(KW)) u_prep_a (
        .in_x      (in_a),
        .in_signed (in_signed),
        .approx_en (approx_en),
        .trunc_k   (trunc_k),
        .out_mag   (w_mag_a),
        .out_sign  (w_sign_a)
    );

    approx_operand_prep #(.WIDTH(WIDTH), .KW(KW)) u_prep_b (
        .in_x      (in_b),
        .in_signed (in_signed),
        .approx_en (approx_en),
        .trunc_k   (trunc_k),
        .out_mag   (w_mag_b),
        .out_sign  (w_sign_b)
    );

    always_comb begin
        w_ma_sh    = {{WIDTH{1'b0}}, r_ma} << r_cnt;
        w_acc_next = r_mb[r_cnt] ? (r_acc + w_ma_sh) : r_acc;
        w_last     = (r_cnt == KW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_neg       <= 1'b0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_ma    <= w_mag_a;
                        r_mb    <= w_mag_b;
                        r_neg   <= w_sign_a ^ w_sign_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + KW'(1);
                    // The last partial product is folded in and the sign applied in the same edge.
                    if (w_last) begin
                        r_product   <= r_neg ? (~w_acc_next + PW'(1)) : w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = r_out_valid;
    assign out_product = r_product;
    assign busy        = r_busy;

endmodule

// File: tb/tb_approx_mult_iter.sv
// Directed bench for approx_mult_iter at WIDTH = 16.
module tb_approx_mult_iter;

    localparam int W  = 16;
    localparam int KW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_signed = 1'b0;
    logic          approx_en = 1'b0;
    logic [KW-1:0] trunc_k = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*W-1:0] out_product;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    approx_mult_iter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_signed   (in_signed),
        .approx_en   (approx_en),
        .trunc_k     (trunc_k),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .busy        (busy)
    );

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           sgn;
        logic           ap;
        logic [KW-1:0]  k;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Accepts one operation and waits for out_valid; returns the cycle count.
    task automatic start_and_wait(input vec_t v, output int lat);
        lat = -1;
        @(negedge clk);
        in_a = v.a; in_b = v.b; in_signed = v.sgn; approx_en = v.ap; trunc_k = v.k;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = ~v.a; in_b = ~v.b; in_signed = ~v.sgn; approx_en = ~v.ap; trunc_k = ~v.k;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        start_and_wait(v, lat);
        chk({name, " latency"}, 64'(lat), 64'd16);
        chk({name, " product"}, 64'(out_product), 64'(v.exp));
        drain();
    endtask

    initial begin
        int   lat;
        vec_t v;
        logic [2*W-1:0] held;

        vecs[0]  = '{16'd300,  16'd200,  1'b0, 1'b0, 4'd0,  32'h0000EA60};
        vecs[1]  = '{16'd300,  16'd200,  1'b0, 1'b1, 4'd4,  32'h0000D800};
        vecs[2]  = '{16'hFFF9, 16'd5,    1'b1, 1'b0, 4'd0,  32'hFFFFFFDD};
        vecs[3]  = '{16'hFFF9, 16'd5,    1'b1, 1'b1, 4'd2,  32'hFFFFFFE0};
        vecs[4]  = '{16'h8000, 16'h8000, 1'b1, 1'b0, 4'd0,  32'h40000000};
        vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 4'd0,  32'hFFFE0001};
        vecs[6]  = '{16'd0,    16'd1234, 1'b0, 1'b0, 4'd0,  32'h00000000};
        vecs[7]  = '{16'h8000, 16'd1,    1'b1, 1'b0, 4'd0,  32'hFFFF8000};
        vecs[8]  = '{16'd300,  16'd200,  1'b0, 1'b1, 4'd0,  32'h0000EA60};
        vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 4'd15, 32'h40000000};
        vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 4'd0,  32'h00000001};
        vecs[11] = '{16'd7,    16'd7,    1'b0, 1'b0, 4'd4,  32'h00000031};

        #2;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_product", 64'(out_product), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure with a competing request held on the input.
        v = vecs[0];
        start_and_wait(v, lat);
        chk("bp latency", 64'(lat), 64'd16);
        held = out_product;
        chk("bp product", 64'(held), 64'h0000EA60);
        in_a = 16'd3; in_b = 16'd3; in_signed = 1'b0; approx_en = 1'b0; trunc_k = '0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp out_valid", 64'(out_valid), 64'd1);
            chk("bp hold", 64'(out_product), 64'(held));
            chk("bp busy", 64'(busy), 64'd1);
            chk("bp in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp exit out_valid", 64'(out_valid), 64'd0);
        chk("bp exit in_ready", 64'(in_ready), 64'd1);
        chk("bp exit busy", 64'(busy), 64'd0);
        chk("bp idle retains", 64'(out_product), 64'(held));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp second accept", 64'(busy), 64'd1);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        chk("bp2 latency", 64'(lat), 64'd16);
        chk("bp2 product", 64'(out_product), 64'd9);
        drain();

        // Reset abort in the middle of the iteration.
        v = vecs[5];
        @(negedge clk);
        in_a = v.a; in_b = v.b; in_signed = v.sgn; approx_en = v.ap; trunc_k = v.k;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort out_product", 64'(out_product), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort in_ready", 64'(in_ready), 64'd1);
        v = '{16'd3, 16'd3, 1'b0, 1'b0, 4'd0, 32'd9};
        run_vec(v, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
